// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU-sharing arbiter.
// Optional build macro used by the arbiter: ALU_ARB_FIXED_PRIO_EN.
package alu_share_pkg;

    localparam int DEF_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SHL = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    // Arbiter FSM encodings
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/alu_share_core.sv
// Combinational W-bit four-function ALU with a W+1 bit result.
// Bit W carries the add carry, the subtract borrow or the bit shifted out by shl1.
module alu_share_core
    import alu_share_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   sel,
    output logic [W:0]   result
);

    // Select the operation; zero-extended operands make bit W the carry/borrow
    always_comb begin
        // NOTE: default assignment first so no path leaves result unassigned (no latch).
        result = '0;
        case (op_e'(sel))
            OP_ADD:  result = {1'b0, a} + {1'b0, b};
            OP_SUB:  result = {1'b0, a} - {1'b0, b};
            OP_SHL:  result = {a, 1'b0};
            OP_XOR:  result = {1'b0, a ^ b};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one alu_share_core between NREQ requesters: grant, latch operands,
// execute for one registered cycle, then hold the result on a valid/ready port.
// Build macro ALU_ARB_FIXED_PRIO_EN: when defined, lowest-index valid requester
// always wins and the round-robin pointer does not exist.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = DEF_W,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ*2-1:0]   req_sel,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [W:0]          rsp_data,
    output logic                busy
);

    logic [1:0]     state;
    logic           any_valid;
    logic [IDW-1:0] grant;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [1:0]     op_sel;
    logic [IDW-1:0] op_id;
    logic [W:0]     alu_result;

    // First valid requester found scanning ptr, ptr+1, ... wrapping at NREQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  ptr);
        logic [2*NREQ-1:0] dbl;
        int off;
        int sum;
        dbl = {valid, valid} >> ptr;
        off = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (dbl[k]) off = k;
        end
        sum = int'(ptr) + off;
        if (sum >= NREQ) sum = sum - NREQ;
        return IDW'(sum);
    endfunction

    assign any_valid = |req_valid;
    assign busy      = (state != IDLE);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant = rr_pick(req_valid, '0);
`else
    logic [IDW-1:0] rr_ptr;

    assign grant = rr_pick(req_valid, rr_ptr);

    // Pointer moves just past the requester whose response was accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (state == RESP && rsp_ready) begin
            rr_ptr <= (op_id == IDW'(NREQ - 1)) ? '0 : op_id + 1'b1;
        end
    end
`endif

    // Accept goes to the granted requester only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (state == IDLE && any_valid && rst_n) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Capture the winner's command on transfer
    always_ff @(posedge clk) begin
        // NOTE: pure datapath holding registers carry no reset; state gates their use.
        if (state == IDLE && any_valid) begin
            op_a   <= req_a[int'(grant)*W +: W];
            op_b   <= req_b[int'(grant)*W +: W];
            op_sel <= req_sel[int'(grant)*2 +: 2];
            op_id  <= grant;
        end
    end

    alu_share_core #(.W(W)) u_core (
        .a      (op_a),
        .b      (op_b),
        .sel    (op_sel),
        .result (alu_result)
    );

    // Control FSM and registered response port
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) state <= EXEC;
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= alu_result;
                    rsp_id    <= op_id;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
